// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register width, scoreboard entry and the
// sequencing-controller state encoding.
package cpu_pkg;

  localparam int REG_W            = 5;
  localparam int SB_DEPTH         = 3;  // EX, MEM, WR
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rw;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request and pipeline-register control bundle between the
// decode stage and hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [cpu_pkg::REG_W-1:0] id_rs;
  logic [cpu_pkg::REG_W-1:0] id_rt;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic                      id_reg_wr;
  logic [cpu_pkg::REG_W-1:0] id_rw;
  logic                      ex_branch_taken;

  logic                      if_stall;
  logic                      id_stall;
  logic                      idex_bubble;
  logic                      ifid_flush;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_wr, id_rw, ex_branch_taken,
    input  if_stall, id_stall, idex_bubble, ifid_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_wr, id_rw, ex_branch_taken,
    output if_stall, id_stall, idex_bubble, ifid_flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_cmp.sv
// One source register compared against every in-flight destination;
// $0 and unused sources never match.
module hazard_cmp
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]            src_i,
  input  logic                        use_i,
  input  sb_entry_t [SB_DEPTH-1:0]    sb_i,
  output logic                        match_o
);

  logic [SB_DEPTH-1:0] hit;

  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_hit
    assign hit[g] = sb_i[g].valid && (sb_i[g].rw == src_i);
  end

  assign match_o = use_i && (src_i != '0) && (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: RAW stall via destination scoreboard and
// taken-branch squash FSM. Optional perf counters under `PERF_CNT_EN`.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int FL_W = 2;

  hz_state_e                 state_q, state_d;
  logic [FL_W-1:0]           flush_left_q, flush_left_d;
  sb_entry_t [SB_DEPTH-1:0]  sb_q, sb_d;   // [0]=EX [1]=MEM [2]=WR

  logic rs_match, rt_match, hazard;
  logic if_stall, id_stall, idex_bubble, ifid_flush;

  hazard_cmp u_cmp_rs (.src_i(hz.id_rs), .use_i(hz.id_uses_rs), .sb_i(sb_q), .match_o(rs_match));
  hazard_cmp u_cmp_rt (.src_i(hz.id_rt), .use_i(hz.id_uses_rt), .sb_i(sb_q), .match_o(rt_match));

  // WR matches count too: the regfile write and the ID/EX capture share an edge.
  assign hazard = rs_match || rt_match;

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    if_stall     = 1'b0;
    id_stall     = 1'b0;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.ex_branch_taken) begin
          ifid_flush   = 1'b1;
          idex_bubble  = 1'b1;
          flush_left_d = FL_W'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES > 1) state_d = FLUSH;
        end else if (hazard) begin
          if_stall    = 1'b1;
          id_stall    = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        // ID holds a squashed instruction: its hazards and branches are moot.
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        flush_left_d = flush_left_q - 1'b1;
        if (flush_left_q == FL_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    sb_d          = sb_q;
    sb_d[2]       = sb_q[1];
    sb_d[1]       = sb_q[0];
    sb_d[0].valid = !idex_bubble && hz.id_reg_wr && (hz.id_rw != '0);
    sb_d[0].rw    = idex_bubble ? '0 : hz.id_rw;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_left_q <= '0;
      sb_q         <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      sb_q         <= sb_d;
    end
  end

  assign hz.if_stall    = if_stall;
  assign hz.id_stall    = id_stall;
  assign hz.idex_bubble = idex_bubble;
  assign hz.ifid_flush  = ifid_flush;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating: a pinned all-ones value means "at least this many".
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (if_stall && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: cycle table of ID inputs with expected
// controls/counters, plus an async-reset-during-flush sequence.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;   // active edge is negedge; checks at posedge

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, wr;
    logic [4:0] rw;
    logic       br;
    logic [3:0] exp;   // {if_stall, id_stall, idex_bubble, ifid_flush}
    int         sc, fc;
  } vec_t;

  vec_t vt[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(int rs, int rt, int urs, int urt, int wr, int rw,
                              int br, logic [3:0] exp, int sc, int fc);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt);
    v.wr = 1'(wr); v.rw = 5'(rw); v.br = 1'(br);
    v.exp = exp; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz_if.id_rs           = v.rs;
    hz_if.id_rt           = v.rt;
    hz_if.id_uses_rs      = v.urs;
    hz_if.id_uses_rt      = v.urt;
    hz_if.id_reg_wr       = v.wr;
    hz_if.id_rw           = v.rw;
    hz_if.ex_branch_taken = v.br;
  endtask

  function automatic logic [3:0] outs();
    return {hz_if.if_stall, hz_if.id_stall, hz_if.idex_bubble, hz_if.ifid_flush};
  endfunction

  function automatic int cexp(int v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk_cnt(input string name, input int sc, input int fc);
    chk({name, " stall_cnt"}, 32'(hz_if.stall_cnt), 32'(cexp(sc)));
    chk({name, " flush_cnt"}, 32'(hz_if.flush_cnt), 32'(cexp(fc)));
  endtask

  // Drive a cycle after the active edge, check at posedge, advance past next negedge.
  task automatic step(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    chk({name, " outs"}, 32'(outs()), 32'(v.exp));
    chk_cnt(name, v.sc, v.fc);
    @(negedge clk);
    #1;
  endtask

  initial begin
    vec_t nop;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    drive(nop);

    // rs  rt urs urt wr rw br   exp    sc fc
    vt.push_back(mk( 1, 2, 1, 1, 1, 3, 0, 4'b0000, 0, 0));  // add $3
    vt.push_back(mk( 3, 5, 1, 1, 1, 4, 0, 4'b1110, 0, 0));  // $3 in EX
    vt.push_back(mk( 3, 5, 1, 1, 1, 4, 0, 4'b1110, 1, 0));  // $3 in MEM
    vt.push_back(mk( 3, 5, 1, 1, 1, 4, 0, 4'b1110, 2, 0));  // $3 in WR
    vt.push_back(mk( 3, 5, 1, 1, 1, 4, 0, 4'b0000, 3, 0));  // issues
    vt.push_back(mk( 1, 2, 1, 1, 1, 0, 0, 4'b0000, 3, 0));  // add $0
    vt.push_back(mk( 0, 0, 1, 1, 1, 8, 0, 4'b0000, 3, 0));  // reads $0
    vt.push_back(mk( 0, 0, 0, 0, 1, 7, 0, 4'b0000, 3, 0));  // writes $7
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0));
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0));
    vt.push_back(mk( 1, 7, 1, 0, 0, 0, 0, 4'b0000, 3, 0));  // $7 in WR, rt unused
    vt.push_back(mk( 0, 0, 0, 0, 1, 7, 0, 4'b0000, 3, 0));  // writes $7 again
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0));
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 0));
    vt.push_back(mk( 1, 7, 1, 1, 0, 0, 0, 4'b1110, 3, 0));  // sw, $7 in WR
    vt.push_back(mk( 1, 7, 1, 1, 0, 0, 0, 4'b0000, 4, 0));
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 4'b0011, 4, 0));  // branch taken
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4, 1));  // FLUSH
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4, 2));  // back in RUN
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 4'b0011, 4, 2));  // branch taken
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 1, 4'b0011, 4, 3));  // ignored in FLUSH
    vt.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4, 4));
    vt.push_back(mk( 0, 0, 0, 0, 1, 9, 0, 4'b0000, 4, 4));  // writes $9
    vt.push_back(mk( 9, 0, 1, 0, 1,10, 1, 4'b0011, 4, 4));  // hazard + branch
    vt.push_back(mk( 9, 0, 1, 0, 1,10, 0, 4'b0011, 4, 5));  // squashed $10 writer
    vt.push_back(mk(10, 0, 1, 0, 0, 0, 0, 4'b0000, 4, 6));  // $10 never entered sb

    #2;
    chk("reset outs", 32'(outs()), 32'h0);
    chk_cnt("reset", 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      step($sformatf("row%0d", i), vt[i]);

    // Reset while flushing with live scoreboard entries.
    step("rst_seq0", mk( 0, 0, 0, 0, 1,11, 0, 4'b0000, 4, 6));
    step("rst_seq1", mk( 0, 0, 0, 0, 1,12, 0, 4'b0000, 4, 6));
    step("rst_seq2", mk( 0, 0, 0, 0, 1,13, 1, 4'b0011, 4, 6));
    drive(mk(12, 11, 1, 1, 0, 0, 0, 4'b0000, 0, 0));
    @(posedge clk);
    chk("mid_flush outs", 32'(outs()), 32'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst outs", 32'(outs()), 32'h0);
    chk_cnt("async_rst", 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", mk(12, 11, 1, 1, 1, 14, 0, 4'b0000, 0, 0));
    step("post_rst_dep", mk(14, 0, 1, 0, 0, 0, 0, 4'b1110, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage CPU (IF/ID/EX/MEM/WR). It tracks in-flight register writes in a three-entry destination scoreboard and holds IF and ID on read-after-write hazards; the pipeline has no forwarding. It runs a flush state machine that squashes wrong-path instructions after a branch resolves taken in EX. It drives the hold, bubble and flush controls of the IF/ID and ID/EX pipeline registers.

## Interface
- FLUSH_CYCLES, 2: cycles of squash after a taken branch (1..3).
- CNT_W, 16: width of performance counters.
- clk  in  1  pipeline clock; all state updates on negedge clk, same edge as the pipeline registers.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  Rs field of instruction in ID.
- id_rt  in  5  Rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads Rs.
- id_uses_rt  in  1  ID instruction reads Rt (R-type, sw, beq, bne).
- id_reg_wr  in  1  ID instruction writes the register file.
- id_rw  in  5  ID destination register (RegDst already applied).
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- if_stall  out  1  hold PC / fetch.
- id_stall  out  1  hold IF/ID register.
- idex_bubble  out  1  load zero controls (RegWr=0, MemWr=0, branch=0) into ID/EX.
- ifid_flush  out  1  load a NOP into IF/ID.
- stall_cnt  out  CNT_W  hazard-stall cycles (PERF_CNT_EN only).
- flush_cnt  out  CNT_W  flush cycles (PERF_CNT_EN only).

## Operation
- Scoreboard entries sb_ex, sb_mem, sb_wr, each {valid, rw[4:0]}; they shadow the destinations of the instructions in EX, MEM and WR.
- Each edge: sb_mem<=sb_ex, sb_wr<=sb_mem. sb_ex<={0,0} if idex_bubble, else {id_reg_wr & (id_rw!=0), id_rw}.
- hazard (combinational) = (id_uses_rs & id_rs!=0 & rs matches any valid entry) | (the same test for rt). Register $0 never hazards.
- A WR-stage match counts as a hazard, because the register file write and the ID/EX capture share an edge.
- FSM states: RUN, FLUSH.
  - RUN: if ex_branch_taken, then ifid_flush=1 and idex_bubble=1, load flush_left=FLUSH_CYCLES-1, and go to FLUSH when FLUSH_CYCLES>1. Else if hazard, then if_stall=id_stall=idex_bubble=1. Else all outputs are 0.
  - FLUSH: ifid_flush=1 and idex_bubble=1; decrement flush_left and return to RUN at 0. Hazards are ignored because the ID instruction is being squashed.
- Priority: ex_branch_taken > hazard. A taken branch during a stall cancels the stall that cycle.
- ex_branch_taken while already in FLUSH is ignored; the squashed instruction cannot branch.

## Timing
- Reset: FSM=RUN, flush_left=0, every scoreboard valid=0, counters=0, so if_stall=id_stall=idex_bubble=ifid_flush=0.
- Stall outputs are combinational from ID inputs and state; no added latency.
- Load-use or ALU dependence stall length:
  - 3 cycles if the producer is in EX.
  - 2 cycles if the producer is in MEM.
  - 1 cycle if the producer is in WR.
- Taken-branch penalty is exactly FLUSH_CYCLES bubbles.
- rst_n asserted mid-stall or mid-flush clears everything immediately. The first edge after release behaves as RUN with an empty scoreboard.

## Configuration
- PERF_CNT_EN defined: stall_cnt increments on each edge where hazard-stall is asserted in RUN. flush_cnt increments each cycle ifid_flush=1. Both saturate at all-ones and do not wrap.
- PERF_CNT_EN undefined: counter registers are not built and stall_cnt and flush_cnt are tied to 0.

## Structure
- Shared package cpu_pkg: REG_W=5, the sb_entry_t struct {valid, rw}, the FSM state enum, and FLUSH_CYCLES default.
- Sub-module hazard_cmp: one 5-bit source vs three scoreboard entries, giving a match bit. Instantiate it twice, once for rs and once for rt.

## Test plan
- add $3 (writes $3) then add $4,$3,$5 back-to-back: if_stall and id_stall high for exactly 3 cycles, 3 bubbles enter EX, stall_cnt=3.
- add $0 followed by a reader of $0: no stall.
- sw reading $7 with $7 pending only in sb_wr: 1-cycle stall. With id_uses_rt=0: no stall.
- ex_branch_taken pulse, FLUSH_CYCLES=2: ifid_flush high for 2 cycles, then RUN, flush_cnt=2.
- Hazard stall active when ex_branch_taken=1: stall drops and flush takes over. Scoreboard gets bubbles, so no spurious stall afterward.
- rst_n low in the middle of FLUSH with sb full: all outputs 0 asynchronously, scoreboard empty, and the next dependent instruction does not stall.
